// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// instruction-fetch (IF) and data-memory (DM) requesters. DM has priority;
// a starvation counter forces an IF grant after STARVE_LIMIT consecutive DM
// grants made while IF was waiting.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction in flight, arbitration happens here
// ISSUE | mem_en strobe, latched address/we/wdata on the memory port
// WAIT  | down-counting the remaining memory latency
// DONE  | one-cycle ready pulse to the granted requester
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // WAIT lasts LATENCY-1 cycles; zero means ISSUE goes straight to DONE.
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       grant_now;
  logic       win_dm;

  // Arbitration: DM wins unless IF is waiting and has hit the starvation limit.
  always_comb begin
    grant_now = 1'b0;
    win_dm    = 1'b0;
    if (state == S_IDLE && (if_req || dm_req)) begin
      grant_now = 1'b1;
      win_dm    = dm_req && !(if_req && starve_cnt == LIMIT);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    busy      = 1'b1;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (grant_now) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en    = 1'b1;
        state_nxt = (LAT_LOAD == 4'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == 4'd1) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (grant_dm) begin
          dm_ready = 1'b1;
          dm_rdata = mem_rdata;
        end else begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's request at the grant edge; hold it until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_dm  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_now) begin
      grant_dm  <= win_dm;
      mem_we    <= win_dm && dm_we;
      mem_addr  <= win_dm ? dm_addr : if_addr;
      mem_wdata <= win_dm ? dm_wdata : '0;
    end
  end

  // Latency down-counter: loaded in ISSUE, terminal count ends WAIT.
  always_ff @(posedge clk) begin
    if (rst)                  lat_cnt <= 4'd0;
    else if (state == S_ISSUE) lat_cnt <= LAT_LOAD;
    else if (state == S_WAIT)  lat_cnt <= lat_cnt - 4'd1;
  end

  // Starvation count: consecutive DM grants taken while IF was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_now) begin
      if (win_dm && if_req) begin
        if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY=2/STARVE_LIMIT=2 and
// LATENCY=1/STARVE_LIMIT=4), a transaction-level reference model that
// schedules each grant by absolute cycle number, a hand-written vector table,
// directed corner sequences and a randomized phase.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_ready  [2];
  logic        dm_req    [2];
  logic        dm_we     [2];
  logic [31:0] dm_addr   [2];
  logic [31:0] dm_wdata  [2];
  logic [31:0] dm_rdata  [2];
  logic        dm_ready  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];
  logic        grant_dm  [2];
  logic [3:0]  sc        [2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .STARVE_LIMIT(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_ready(dm_ready[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .grant_dm(grant_dm[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_ready(dm_ready[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .grant_dm(grant_dm[1])
  );

  assign sc[0] = u_dut0.starve_cnt;
  assign sc[1] = u_dut1.starve_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Memory behind each instance (environment) and the model's view of it.
  bit [31:0] env_ram [2][256];
  bit [31:0] mdl_ram [2][256];

  // Reference model: one scheduled transaction per instance.
  int        lat [2] = '{2, 1};
  int        lim [2] = '{2, 4};
  int        m_issue [2];
  int        m_done  [2];
  bit        m_gdm   [2];
  bit        m_we    [2];
  bit [31:0] m_addr  [2];
  bit [31:0] m_wdata [2];
  int        m_starve[2];
  bit        m_rst   [2];
  bit        exp_ifr [2];
  bit        exp_dmr [2];

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Decide what the coming edge does, from the inputs about to be sampled.
  task automatic model_edge(input int i);
    bit win;
    m_rst[i] = 1'b0;
    if (rst) begin
      m_issue[i] = -100; m_done[i] = -100;
      m_gdm[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_wdata[i] = 0;
      m_starve[i] = 0; m_rst[i] = 1'b1;
    end else if ((cyc < m_issue[i] || cyc > m_done[i]) && (if_req[i] || dm_req[i])) begin
      win = dm_req[i] && !(if_req[i] && m_starve[i] == lim[i]);
      if (!win)          m_starve[i] = 0;
      else if (if_req[i]) m_starve[i] = (m_starve[i] + 1 > lim[i]) ? lim[i] : m_starve[i] + 1;
      else               m_starve[i] = 0;
      m_gdm[i]   = win;
      m_addr[i]  = win ? dm_addr[i] : if_addr[i];
      m_we[i]    = win && dm_we[i];
      m_wdata[i] = win ? dm_wdata[i] : 32'h0;
      m_issue[i] = cyc + 1;
      m_done[i]  = cyc + 1 + lat[i];
      if (m_we[i]) mdl_ram[i][m_addr[i][7:0]] = m_wdata[i];
    end
  endtask

  task automatic check_inst(input int i);
    bit        b, r;
    bit [31:0] rd;
    b  = (cyc >= m_issue[i]) && (cyc <= m_done[i]);
    r  = (cyc == m_done[i]);
    rd = mdl_ram[i][m_addr[i][7:0]];
    exp_ifr[i] = r && !m_gdm[i];
    exp_dmr[i] = r && m_gdm[i];
    chk("busy",       i, busy[i],     b);
    chk("mem_en",     i, mem_en[i],   cyc == m_issue[i]);
    chk("if_ready",   i, if_ready[i], exp_ifr[i]);
    chk("dm_ready",   i, dm_ready[i], exp_dmr[i]);
    chk("if_rdata",   i, if_rdata[i], exp_ifr[i] ? rd : 32'h0);
    chk("dm_rdata",   i, dm_rdata[i], exp_dmr[i] ? rd : 32'h0);
    chk("grant_dm",   i, grant_dm[i], m_gdm[i]);
    chk("starve_cnt", i, sc[i],       m_starve[i]);
    if (b || m_rst[i]) begin
      chk("mem_addr", i, mem_addr[i], m_addr[i]);
      chk("mem_we",   i, mem_we[i],   m_we[i]);
    end
    if ((b && m_gdm[i]) || m_rst[i]) chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
  endtask

  // One clock: memory write and model update before the edge, checks after.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i] && mem_we[i]) env_ram[i][mem_addr[i][7:0]] = mem_wdata[i];
      model_edge(i);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++)
      mem_rdata[i] = (cyc == m_done[i]) ? env_ram[i][mem_addr[i][7:0]] : $urandom;
    #1;
    for (int i = 0; i < 2; i++) check_inst(i);
  endtask

  task automatic idle_all(input int n);
    for (int i = 0; i < 2; i++) begin if_req[i] = 0; dm_req[i] = 0; end
    for (int k = 0; k < n; k++) step();
  endtask

  typedef struct {
    logic        ifr, dmr;
    logic [31:0] ea;
    logic        e_en, e_ifr, e_dmr, e_busy, e_gdm;
  } vec_t;

  vec_t tbl [8];
  bit   exp_g [6] = '{1, 1, 0, 1, 1, 0};
  bit   g     [6];
  bit   if_pend [2];
  bit   dm_pend [2];

  initial begin
    int ng, nr, last, n;
    bit prev_en, done, was_rst;

    // Contention on instance 0: both rise together, DM first, IF next.
    tbl[0] = '{1, 1, 32'h20, 1, 0, 0, 1, 1};
    tbl[1] = '{1, 1, 32'h20, 0, 0, 0, 1, 1};
    tbl[2] = '{1, 1, 32'h20, 0, 0, 1, 1, 1};
    tbl[3] = '{1, 0, 32'h20, 0, 0, 0, 0, 1};
    tbl[4] = '{1, 0, 32'h30, 1, 0, 0, 1, 0};
    tbl[5] = '{1, 0, 32'h30, 0, 0, 0, 1, 0};
    tbl[6] = '{1, 0, 32'h30, 0, 1, 0, 1, 0};
    tbl[7] = '{0, 0, 32'h30, 0, 0, 0, 0, 0};

    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 256; j++) begin
        env_ram[i][j] = $urandom;
        mdl_ram[i][j] = env_ram[i][j];
      end
      env_ram[i][8'h10] = 32'h2009_0005;
      mdl_ram[i][8'h10] = 32'h2009_0005;
      if_req[i] = 0; if_addr[i] = 0; dm_req[i] = 0; dm_we[i] = 0;
      dm_addr[i] = 0; dm_wdata[i] = 0; mem_rdata[i] = 0;
      m_issue[i] = -100; m_done[i] = -100; m_gdm[i] = 0; m_we[i] = 0;
      m_addr[i] = 0; m_wdata[i] = 0; m_starve[i] = 0; m_rst[i] = 0;
      if_pend[i] = 0; dm_pend[i] = 0;
    end

    rst = 1;
    step();
    step();
    rst = 0;
    idle_all(2);

    for (int r = 0; r < 8; r++) begin
      if_req[0] = tbl[r].ifr; dm_req[0] = tbl[r].dmr;
      if_addr[0] = 32'h30; dm_addr[0] = 32'h20; dm_we[0] = 0;
      step();
      chk("tbl mem_en",   r, mem_en[0],   tbl[r].e_en);
      chk("tbl if_ready", r, if_ready[0], tbl[r].e_ifr);
      chk("tbl dm_ready", r, dm_ready[0], tbl[r].e_dmr);
      chk("tbl busy",     r, busy[0],     tbl[r].e_busy);
      chk("tbl grant_dm", r, grant_dm[0], tbl[r].e_gdm);
      if (tbl[r].e_busy) chk("tbl mem_addr", r, mem_addr[0], tbl[r].ea);
    end
    idle_all(2);

    // Single fetch.
    if_req[0] = 1; if_addr[0] = 32'h10;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("fetch mem_en", k, mem_en[0], k == 1);
      if (k == 1) begin
        chk("fetch mem_addr", k, mem_addr[0], 32'h10);
        chk("fetch mem_we",   k, mem_we[0],   0);
      end
      chk("fetch if_ready", k, if_ready[0], k == 3);
      chk("fetch dm_ready", k, dm_ready[0], 0);
    end
    chk("fetch if_rdata", 0, if_rdata[0], 32'h2009_0005);
    idle_all(2);

    // Store then load to the same address.
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h40; dm_wdata[0] = 32'hA;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("st_ld mem_en",   k, mem_en[0],   k == 1 || k == 5);
      chk("st_ld dm_ready", k, dm_ready[0], k == 3 || k == 7);
      if (k == 1) chk("st_ld store we", k, mem_we[0], 1);
      if (k == 5) chk("st_ld load we",  k, mem_we[0], 0);
      if (k == 7) chk("st_ld dm_rdata", k, dm_rdata[0], 32'hA);
      if (k == 3) dm_we[0] = 0;
    end
    idle_all(2);

    // Starvation with limit 2: DM, DM, IF, DM, DM, IF.
    if_req[0] = 1; if_addr[0] = 32'h90;
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h80;
    ng = 0;
    for (int k = 0; k < 40 && ng < 6; k++) begin
      step();
      if (mem_en[0]) begin
        g[ng] = grant_dm[0];
        if (!grant_dm[0]) chk("starve clear", ng, sc[0], 0);
        ng++;
      end
    end
    chk("starve grants seen", 0, ng, 6);
    for (int j = 0; j < ng; j++) chk("starve order", j, g[j], exp_g[j]);
    idle_all(6);

    // Reset during WAIT of a DM load.
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h40;
    step();
    step();
    rst = 1;
    step();
    rst = 0; dm_req[0] = 0;
    chk("rst busy",     0, busy[0],     0);
    chk("rst mem_en",   0, mem_en[0],   0);
    chk("rst dm_ready", 0, dm_ready[0], 0);
    chk("rst grant_dm", 0, grant_dm[0], 0);
    chk("rst mem_addr", 0, mem_addr[0], 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst no dm_ready", k, dm_ready[0], 0);
    end
    if_req[0] = 1; if_addr[0] = 32'h10;
    done = 0; n = 0;
    for (int k = 1; k <= 10 && !done; k++) begin
      step();
      n = k;
      if (if_ready[0]) done = 1;
    end
    chk("rst fetch completes", 0, done, 1);
    chk("rst fetch latency",   0, n, 3);
    chk("rst fetch rdata",     0, if_rdata[0], 32'h2009_0005);
    idle_all(2);

    // LATENCY=1 instance: back-to-back fetches.
    if_req[1] = 1; if_addr[1] = 32'h20;
    prev_en = 0; last = -1; nr = 0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k > 1) chk("l1 mem_en back-to-back", k, mem_en[1] && prev_en, 0);
      prev_en = mem_en[1];
      if (if_ready[1]) begin
        if (last >= 0) chk("l1 ready spacing", k, k - last, 3);
        last = k;
        nr++;
      end
    end
    chk("l1 ready count", 1, nr, 4);
    idle_all(2);

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 2; i++) begin exp_ifr[i] = 0; exp_dmr[i] = 0; end
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_ifr[i]) if_pend[i] = 0;
        if (exp_dmr[i]) dm_pend[i] = 0;
        if (!if_pend[i] && $urandom_range(0, 2) == 0) begin
          if_pend[i] = 1; if_addr[i] = $urandom_range(0, 255);
        end
        if (!dm_pend[i] && $urandom_range(0, 2) == 0) begin
          dm_pend[i] = 1; dm_addr[i] = $urandom_range(0, 255);
          dm_we[i] = 1'($urandom_range(0, 1)); dm_wdata[i] = $urandom;
        end
        if (if_pend[i] && $urandom_range(0, 63) == 0) if_pend[i] = 0;
        if_req[i] = if_pend[i];
        dm_req[i] = dm_pend[i];
      end
      rst = ($urandom_range(0, 499) == 0);
      was_rst = rst;
      step();
      rst = 0;
      if (was_rst) for (int i = 0; i < 2; i++) begin if_pend[i] = 0; dm_pend[i] = 0; end
    end
    idle_all(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
